pic_inta_sequencer: RTL and testbench

// - Clocked INTA-cycle controller of the 8259 PIC, 8086 mode (two INTA pulses).
// - Resolves priority over pending IRs, raises INT, sequences both INTA pulses,

---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_inta_sequencer_if.sv | 23 ++
 rtl/pic_inta_sequencer_resolver.sv | 27 ++
 rtl/pic_inta_sequencer.sv | 145 ++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style INTA sequencer: FSM states, IR sizing
// and a lowest-index-first priority encoder.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int ID_W   = $clog2(NUM_IR);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2
  } state_t;

  // Returns {found, index} of the lowest-index set bit; bit 0 is the highest priority.
  function automatic logic [ID_W:0] prio_first(input logic [NUM_IR-1:0] vec);
    logic [ID_W:0] result;
    result = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (vec[i]) result = {1'b1, ID_W'(i)};
    end
    return result;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// CPU-side and cascade-side pins of the INTA sequencer: acknowledge, INT, cascade bus and vector bus.
interface pic_inta_sequencer_if;
  import pic_pkg::*;

  logic            inta_n;
  logic            int_out;
  logic [ID_W-1:0] cas_in;
  logic [ID_W-1:0] cas_out;
  logic            cas_oe;
  logic [7:0]      data_out;
  logic            data_oe;

  modport master (
    output inta_n, cas_in,
    input  int_out, cas_out, cas_oe, data_out, data_oe
  );

  modport slave (
    input  inta_n, cas_in,
    output int_out, cas_out, cas_oe, data_out, data_oe
  );

endinterface

// File: rtl/pic_inta_sequencer_resolver.sv
// Combinational priority resolver: picks the highest-priority pending request whose
// level is strictly above the highest level currently in service.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] isr,
  output logic              found,
  output logic [ID_W-1:0]   req_win
);

  logic [ID_W:0]     isr_top;
  logic [ID_W:0]     win;
  logic [NUM_IR-1:0] allowed;

  always_comb begin
    isr_top = prio_first(isr);
    for (int i = 0; i < NUM_IR; i++) begin
      allowed[i] = !isr_top[ID_W] || (i < int'(isr_top[ID_W-1:0]));
    end
    win = prio_first(irr & allowed);
  end

  assign found   = win[ID_W];
  assign req_win = win[ID_W-1:0];

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INTA sequencer of an 8259-style PIC: INT generation, two-pulse acknowledge, ISR, cascade and vector.
// Define PIC_AEOI_EN to clear the serviced ISR bit automatically at the end of the second INTA pulse.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pic_inta_sequencer_if.slave  bus,
  input  logic [NUM_IR-1:0]    irr,
  input  logic                 eoi,
  input  logic                 sngl,
  input  logic                 sp,
  input  logic [NUM_IR-1:0]    slave_map,
  input  logic [ID_W-1:0]      slave_id,
  input  logic [4:0]           vec_base,
  output logic [NUM_IR-1:0]    irr_clr,
  output logic [NUM_IR-1:0]    isr
);

  state_t            state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              inta_prev, inta_s, fall, rise;
  logic              found;
  logic [ID_W-1:0]   req_win, win_new, win_id, win_id_next;
  logic              sel, sel_next;
  logic              fall1, leave_ack2, cascade_new, drive_vec;
  logic [ID_W:0]     isr_top;
  logic [NUM_IR-1:0] isr_next, irr_clr_next;
  logic              int_q, int_next;
  logic              cas_oe_q, cas_oe_next, data_oe_q, data_oe_next;
  logic [ID_W-1:0]   cas_out_q, cas_out_next;
  logic [7:0]        data_out_q, data_out_next;

  pic_priority_resolver u_resolver (
    .irr     (irr),
    .isr     (isr),
    .found   (found),
    .req_win (req_win)
  );

  // inta_n idles high, so the chain resets to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      inta_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
      inta_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_prev & ~inta_s;
  assign rise   = ~inta_prev & inta_s;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall) state_next = ACK1;
      ACK1:    if (rise) state_next = GAP;
      GAP:     if (fall) state_next = ACK2;
      ACK2:    if (rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fall1         = (state == IDLE) && fall;
    leave_ack2    = (state == ACK2) && rise;
    win_new       = found ? req_win : ID_W'(NUM_IR - 1);
    cascade_new   = !sngl && sp && slave_map[win_new];
    drive_vec     = sngl || (sp ? !slave_map[win_id] : sel);
    isr_top       = prio_first(isr);
    win_id_next   = win_id;
    sel_next      = sel;
    isr_next      = isr;
    irr_clr_next  = '0;
    cas_oe_next   = cas_oe_q;
    cas_out_next  = cas_out_q;
    data_oe_next  = data_oe_q;
    data_out_next = data_out_q;

    // EOI acts on the pre-update ISR; a same-cycle fall1 set is applied afterwards and wins.
    if (eoi && isr_top[ID_W]) isr_next[isr_top[ID_W-1:0]] = 1'b0;
    if (fall1) begin
      win_id_next  = win_new;
      cas_oe_next  = cascade_new;
      cas_out_next = cascade_new ? win_new : '0;
      if (found) begin
        isr_next[win_new]     = 1'b1;
        irr_clr_next[win_new] = 1'b1;
      end
    end
    if ((state == ACK1) && rise) sel_next = (bus.cas_in == slave_id);
    if ((state == GAP) && fall && drive_vec) begin
      data_oe_next  = 1'b1;
      data_out_next = {vec_base, win_id};
    end
    if (leave_ack2) begin
      cas_oe_next   = 1'b0;
      cas_out_next  = '0;
      data_oe_next  = 1'b0;
      data_out_next = '0;
`ifdef PIC_AEOI_EN
      isr_next[win_id] = 1'b0;
`endif
    end
    int_next = found && (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_id     <= '0;
      sel        <= 1'b0;
      isr        <= '0;
      irr_clr    <= '0;
      int_q      <= 1'b0;
      cas_oe_q   <= 1'b0;
      cas_out_q  <= '0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state      <= state_next;
      win_id     <= win_id_next;
      sel        <= sel_next;
      isr        <= isr_next;
      irr_clr    <= irr_clr_next;
      int_q      <= int_next;
      cas_oe_q   <= cas_oe_next;
      cas_out_q  <= cas_out_next;
      data_oe_q  <= data_oe_next;
      data_out_q <= data_out_next;
    end
  end

  assign bus.int_out  = int_q;
  assign bus.cas_oe   = cas_oe_q;
  assign bus.cas_out  = cas_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: directed and randomized INTA sequences checked
// against a priority/ISR reference model. Honours PIC_AEOI_EN when defined.
module tb_pic_inta_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irr = '0;
  logic [7:0] slave_map = '0;
  logic       eoi = 1'b0;
  logic       sngl = 1'b1;
  logic       sp = 1'b0;
  logic [2:0] slave_id = '0;
  logic [4:0] vec_base = '0;
  logic [7:0] irr_clr;
  logic [7:0] isr;

  int checks = 0;
  int failures = 0;

  logic [7:0] data_q[$];
  logic [7:0] clr_q[$];
  logic [2:0] cas_q[$];
  logic [7:0] model_isr = '0;

  always #5 clk = ~clk;

  pic_inta_sequencer_if bus ();

  pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .irr       (irr),
    .eoi       (eoi),
    .sngl      (sngl),
    .sp        (sp),
    .slave_map (slave_map),
    .slave_id  (slave_id),
    .vec_base  (vec_base),
    .irr_clr   (irr_clr),
    .isr       (isr)
  );

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // Winning IR, or -1 when nothing beats the current in-service level.
  function automatic int winner(input logic [7:0] req, input logic [7:0] serv);
    int limit;
    limit = lowest_set(serv);
    for (int i = 0; i < limit; i++) if (req[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic waitSample(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveInta(input logic level);
    @(posedge clk);
    #($urandom_range(1, 8));
    bus.inta_n = level;
  endtask

  task automatic issueEoi();
    int top;
    @(posedge clk); #2; eoi = 1'b1;
    @(posedge clk); #2; eoi = 1'b0;
    top = lowest_set(model_isr);
    if (top < 8) model_isr[3'(top)] = 1'b0;
    @(negedge clk);
    checkOutput("isr_after_eoi", 32'(isr), 32'(model_isr));
    @(negedge clk);
    checkOutput("int_out_after_eoi", 32'(bus.int_out), 32'(winner(irr, model_isr) >= 0));
  endtask

  // mode: 0 single, 1 master, 2 slave. irr_later replaces irr once ACK1 is entered.
  task automatic applyStimulus(input int mode, input logic [7:0] irr_v, input logic [7:0] map_v,
                               input logic [2:0] sid, input logic [2:0] cin, input logic [4:0] vb,
                               input logic [7:0] irr_later);
    int w;
    logic [2:0] id;
    logic cascade, drive;
    @(posedge clk); #2;
    sngl = (mode == 0);
    sp = (mode == 1);
    slave_map = map_v;
    slave_id = sid;
    bus.cas_in = cin;
    vec_base = vb;
    irr = irr_v;
    waitSample(3);
    w = winner(irr_v, model_isr);
    checkOutput("int_out_pending", 32'(bus.int_out), 32'(w >= 0));
    id = (w >= 0) ? 3'(w) : 3'd7;
    cascade = (mode == 1) && map_v[id];
    drive = (mode == 0) || ((mode == 1) && !map_v[id]) || ((mode == 2) && (cin == sid));
    if (w >= 0) begin
      clr_q.push_back(8'(1) << id);
      model_isr[id] = 1'b1;
    end
    if (cascade) cas_q.push_back(id);
    if (drive) data_q.push_back({vb, id});

    driveInta(1'b0); waitSample(4);
    checkOutput("int_out_ack1", 32'(bus.int_out), 32'd0);
    checkOutput("cas_oe_ack1", 32'(bus.cas_oe), 32'(cascade));
    checkOutput("data_oe_ack1", 32'(bus.data_oe), 32'd0);
    irr = irr_later;
    driveInta(1'b1); waitSample(4 + int'($urandom_range(0, 3)));
    checkOutput("cas_oe_gap", 32'(bus.cas_oe), 32'(cascade));
    driveInta(1'b0); waitSample(4);
    checkOutput("cas_oe_ack2", 32'(bus.cas_oe), 32'(cascade));
    checkOutput("data_oe_ack2", 32'(bus.data_oe), 32'(drive));
    driveInta(1'b1); waitSample(4);
`ifdef PIC_AEOI_EN
    model_isr[id] = 1'b0;
`endif
    checkOutput("cas_oe_idle", 32'(bus.cas_oe), 32'd0);
    checkOutput("data_oe_idle", 32'(bus.data_oe), 32'd0);
    checkOutput("data_out_idle", 32'(bus.data_out), 32'd0);
    checkOutput("isr_after_seq", 32'(isr), 32'(model_isr));
    checkOutput("data_q_drained", 32'(data_q.size()), 32'd0);
    checkOutput("cas_q_drained", 32'(cas_q.size()), 32'd0);
    checkOutput("clr_q_drained", 32'(clr_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a vector, a cascade ID or an IRR clear.
  initial begin : monitor
    logic data_oe_d, cas_oe_d;
    data_oe_d = 1'b0;
    cas_oe_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        data_oe_d = 1'b0;
        cas_oe_d = 1'b0;
      end else begin
        if (bus.data_oe && !data_oe_d) begin
          if (data_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_data data_out=%0h expected=none", bus.data_out);
          end else checkOutput("data_out", 32'(bus.data_out), 32'(data_q.pop_front()));
        end
        if (bus.cas_oe && !cas_oe_d) begin
          if (cas_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_cas cas_out=%0h expected=none", bus.cas_out);
          end else checkOutput("cas_out", 32'(bus.cas_out), 32'(cas_q.pop_front()));
        end
        if (irr_clr != 8'h00) begin
          if (clr_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_irr_clr irr_clr=%0h expected=none", irr_clr);
          end else checkOutput("irr_clr", 32'(irr_clr), 32'(clr_q.pop_front()));
        end
        data_oe_d = bus.data_oe;
        cas_oe_d = bus.cas_oe;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int mode;
    logic [2:0] sid, cin;
    bus.inta_n = 1'b1;
    bus.cas_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_int_out", 32'(bus.int_out), 32'd0);
    checkOutput("reset_isr", 32'(isr), 32'd0);
    checkOutput("reset_irr_clr", 32'(irr_clr), 32'd0);
    checkOutput("reset_cas_oe", 32'(bus.cas_oe), 32'd0);
    checkOutput("reset_data_oe", 32'(bus.data_oe), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    applyStimulus(0, 8'b0010_0100, 8'h00, 3'd0, 3'd0, 5'h10, 8'b0010_0100);
    @(posedge clk); #2; irr = 8'h08;
    waitSample(3);
    checkOutput("int_out_below_isr", 32'(bus.int_out), 32'(winner(irr, model_isr) >= 0));
    issueEoi();
    applyStimulus(1, 8'h08, 8'h08, 3'd0, 3'd0, 5'h10, 8'h00);
    issueEoi();
    applyStimulus(2, 8'h01, 8'h00, 3'd3, 3'd3, 5'h08, 8'h00);
    issueEoi();
    applyStimulus(2, 8'h01, 8'h00, 3'd3, 3'd5, 5'h08, 8'h00);
    issueEoi();
    applyStimulus(0, 8'h00, 8'h00, 3'd0, 3'd0, 5'h10, 8'h00);

    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 2));
      sid = 3'($urandom);
      cin = ($urandom_range(0, 1) == 1) ? sid : 3'($urandom);
      applyStimulus(mode, 8'($urandom) & 8'($urandom), 8'($urandom), sid, cin, 5'($urandom), 8'($urandom));
      if ((model_isr != 8'h00) && ($urandom_range(0, 1) == 1)) issueEoi();
    end

    // Abort a sequence in GAP with reset, then confirm a normal sequence still runs.
    for (int k = 0; k < 8; k++) if (model_isr != 8'h00) issueEoi();
    @(posedge clk); #2;
    sngl = 1'b1; sp = 1'b0; irr = 8'h01; vec_base = 5'h04;
    waitSample(3);
    clr_q.push_back(8'h01);
    driveInta(1'b0); waitSample(4);
    driveInta(1'b1); waitSample(4);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_isr", 32'(isr), 32'd0);
    checkOutput("midreset_int_out", 32'(bus.int_out), 32'd0);
    checkOutput("midreset_irr_clr", 32'(irr_clr), 32'd0);
    checkOutput("midreset_cas", 32'({bus.cas_oe, bus.cas_out}), 32'd0);
    checkOutput("midreset_data", 32'({bus.data_oe, bus.data_out}), 32'd0);
    data_q.delete();
    cas_q.delete();
    clr_q.delete();
    model_isr = '0;
    @(posedge clk); #2; rst_n = 1'b1;
    applyStimulus(0, 8'h10, 8'h00, 3'd0, 3'd0, 5'h1f, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
